// File: rtl/scan_chain_controller_pkg.sv
// Shared types and index helpers for the multi-project scan chain controller.
package scan_chain_controller_pkg;

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_LOAD    = 3'd1,
    ST_LATCH   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_UNLOAD  = 3'd4,
    ST_DONE    = 3'd5
  } scan_state_e;

  localparam int NUM_DESIGNS_DEF = 498;
  localparam int CHAIN_LEN_DEF   = 8 * NUM_DESIGNS_DEF;

  // Shift index at which bit_idx of slot sel sits at the far end of the chain.
  function automatic int target_idx(input int num_designs, input int sel, input int bit_idx);
    return 8 * num_designs - 1 - (8 * sel + bit_idx);
  endfunction

endpackage

// File: rtl/scan_shift_sequencer.sv
// Half-phase toggle and shift counter pacing the scan clock (2 clk cycles per shift).
module scan_shift_sequencer #(
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] last_shift,
  output logic             phase_b,
  output logic [CNT_W-1:0] shift_idx,
  output logic             term
);

  logic             phase_r;
  logic [CNT_W-1:0] shift_cnt_r;

  // Phase toggles every enabled cycle; the shift count advances after each phase B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r     <= 1'b0;
      shift_cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      phase_r     <= 1'b0;
      shift_cnt_r <= {CNT_W{1'b0}};
    end else if (enable) begin
      phase_r <= ~phase_r;
      if (phase_r) begin
        shift_cnt_r <= shift_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign phase_b   = phase_r;
  assign shift_idx = shift_cnt_r;
  assign term      = phase_r && (shift_cnt_r == last_shift);

endmodule

// File: rtl/scan_chain_controller.sv
// Loops load / latch / capture / unload over the design scan chain and returns the
// selected design's output byte with a one-cycle ready pulse.
module scan_chain_controller
  import scan_chain_controller_pkg::*;
#(
  parameter int NUM_DESIGNS = NUM_DESIGNS_DEF,
  parameter int SEL_W       = 9
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [SEL_W-1:0] active_select,
  input  logic [7:0]       inputs,
  output logic [7:0]       outputs,
  output logic             ready,
  output logic             scan_clk,
  output logic             scan_data_out,
  input  logic             scan_data_in,
  output logic             scan_select,
  output logic             scan_latch_enable
);

  localparam int CHAIN_L = 8 * NUM_DESIGNS;
  localparam int CNT_W   = $clog2(2 * CHAIN_L + 1);

  scan_state_e      state_r;
  logic [SEL_W-1:0] sel_r;
  logic [7:0]       din_r;
  logic             sel_ok_r;
  logic [7:0]       cap_r;
  logic [7:0]       outputs_r;
  logic             ready_r;
  logic             scan_clk_r;
  logic             sdo_r;
  logic             ssel_r;
  logic             sle_r;

  logic             clear_s;
  logic             enable_s;
  logic [CNT_W-1:0] last_shift_s;
  logic             phase_b_s;
  logic [CNT_W-1:0] shift_idx_s;
  logic             term_s;
  int               idx_s;
  int               sel_int_s;
  logic             hit_s;
  logic [2:0]       hit_bit_s;

  scan_shift_sequencer #(.CNT_W(CNT_W)) u_seq (
    .clk        (clk),
    .rst_n      (resetb),
    .clear      (clear_s),
    .enable     (enable_s),
    .last_shift (last_shift_s),
    .phase_b    (phase_b_s),
    .shift_idx  (shift_idx_s),
    .term       (term_s)
  );

  // Sequencer pacing: long states run L shifts, latch/capture run a single shift slot.
  always_comb begin
    enable_s     = 1'b0;
    last_shift_s = {CNT_W{1'b0}};
    case (state_r)
      ST_LOAD, ST_UNLOAD: begin
        enable_s     = 1'b1;
        last_shift_s = CNT_W'(CHAIN_L - 1);
      end
      ST_LATCH, ST_CAPTURE: begin
        enable_s     = 1'b1;
        last_shift_s = {CNT_W{1'b0}};
      end
      default: begin
        enable_s     = 1'b0;
        last_shift_s = {CNT_W{1'b0}};
      end
    endcase
  end

  assign clear_s   = term_s || (state_r == ST_START) || (state_r == ST_DONE);
  assign idx_s     = 32'(shift_idx_s);
  assign sel_int_s = 32'(sel_r);
  // The selected slot's 8 bits occupy a contiguous window of shift indices.
  assign hit_s     = sel_ok_r && (idx_s >= target_idx(NUM_DESIGNS, sel_int_s, 7))
                              && (idx_s <= target_idx(NUM_DESIGNS, sel_int_s, 0));
  assign hit_bit_s = 3'(target_idx(NUM_DESIGNS, sel_int_s, 0) - idx_s);

  // Main FSM; all chain-facing outputs are registered one cycle behind the state.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_r    <= ST_START;
      sel_r      <= {SEL_W{1'b0}};
      din_r      <= 8'h00;
      sel_ok_r   <= 1'b0;
      cap_r      <= 8'h00;
      outputs_r  <= 8'h00;
      ready_r    <= 1'b0;
      scan_clk_r <= 1'b0;
      sdo_r      <= 1'b0;
      ssel_r     <= 1'b0;
      sle_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_START: begin
          sel_r      <= active_select;
          din_r      <= inputs;
          sel_ok_r   <= (32'(active_select) < NUM_DESIGNS);
          cap_r      <= 8'h00;
          ready_r    <= 1'b0;
          scan_clk_r <= 1'b0;
          sdo_r      <= 1'b0;
          ssel_r     <= 1'b0;
          sle_r      <= 1'b0;
          state_r    <= ST_LOAD;
        end
        ST_LOAD: begin
          ssel_r     <= 1'b0;
          scan_clk_r <= phase_b_s;
          if (!phase_b_s) begin
            sdo_r <= hit_s ? din_r[hit_bit_s] : 1'b0;
          end
          if (term_s) begin
            state_r <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          scan_clk_r <= 1'b0;
          sdo_r      <= 1'b0;
          sle_r      <= ~phase_b_s;
          if (term_s) begin
            state_r <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          sle_r      <= 1'b0;
          ssel_r     <= 1'b1;
          scan_clk_r <= phase_b_s;
          if (term_s) begin
            state_r <= ST_UNLOAD;
          end
        end
        ST_UNLOAD: begin
          ssel_r     <= 1'b0;
          sdo_r      <= 1'b0;
          scan_clk_r <= phase_b_s;
          // Sampled on the edge that raises scan_clk, so the pre-shift bit is seen.
          if (phase_b_s && hit_s) begin
            cap_r[hit_bit_s] <= scan_data_in;
          end
          if (term_s) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          outputs_r  <= cap_r;
          ready_r    <= 1'b1;
          scan_clk_r <= 1'b0;
          sdo_r      <= 1'b0;
          ssel_r     <= 1'b0;
          sle_r      <= 1'b0;
          state_r    <= ST_START;
        end
        default: begin
          ready_r    <= 1'b0;
          scan_clk_r <= 1'b0;
          sdo_r      <= 1'b0;
          ssel_r     <= 1'b0;
          sle_r      <= 1'b0;
          state_r    <= ST_START;
        end
      endcase
    end
  end

  assign outputs           = outputs_r;
  assign ready             = ready_r;
  assign scan_clk          = scan_clk_r;
  assign scan_data_out     = sdo_r;
  assign scan_select       = ssel_r;
  assign scan_latch_enable = sle_r;

endmodule

// File: tb/tb_scan_chain_controller.sv
// Scoreboard bench: models the scan chain and designs (outputs = latched inputs ^ slot index).
module tb_scan_chain_controller;

  localparam int ND  = 4;
  localparam int L   = 8 * ND;
  localparam int T   = 4 * L + 6;
  localparam int NDB = 498;
  localparam int LB  = 8 * NDB;
  localparam int TB  = 4 * LB + 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetb, scan_clk, scan_data_out, scan_data_in, scan_select, scan_latch_enable, ready;
  logic [8:0] active_select;
  logic [7:0] inputs, outputs;

  logic       resetb_b, scan_clk_b, sdo_b, sdi_b, ssel_b, sle_b, ready_b;
  logic [8:0] sel_b;
  logic [7:0] din_b, outputs_b;

  scan_chain_controller #(.NUM_DESIGNS(ND), .SEL_W(9)) u_dut (
    .clk(clk), .resetb(resetb), .active_select(active_select), .inputs(inputs),
    .outputs(outputs), .ready(ready), .scan_clk(scan_clk), .scan_data_out(scan_data_out),
    .scan_data_in(scan_data_in), .scan_select(scan_select), .scan_latch_enable(scan_latch_enable)
  );

  scan_chain_controller #(.NUM_DESIGNS(NDB), .SEL_W(9)) u_dut_big (
    .clk(clk), .resetb(resetb_b), .active_select(sel_b), .inputs(din_b),
    .outputs(outputs_b), .ready(ready_b), .scan_clk(scan_clk_b), .scan_data_out(sdo_b),
    .scan_data_in(sdi_b), .scan_select(ssel_b), .scan_latch_enable(sle_b)
  );

  // Chain + design model for the small instance.
  logic [L-1:0] chain = '0;
  logic [7:0]   latch_m [ND] = '{default: 8'h00};
  assign scan_data_in = chain[L-1];

  always @(posedge scan_clk) begin
    if (scan_select) begin
      for (int a = 0; a < ND; a++) chain[8*a +: 8] <= latch_m[a] ^ 8'(a);
    end else begin
      chain <= {chain[L-2:0], scan_data_out};
    end
  end

  always @(posedge scan_latch_enable) begin
    for (int a = 0; a < ND; a++) latch_m[a] <= chain[8*a +: 8];
  end

  // Chain + design model for the full-size instance.
  logic [LB-1:0] chain_b = '0;
  logic [7:0]    latch_b [NDB] = '{default: 8'h00};
  assign sdi_b = chain_b[LB-1];

  always @(posedge scan_clk_b) begin
    if (ssel_b) begin
      for (int a = 0; a < NDB; a++) chain_b[8*a +: 8] <= latch_b[a] ^ 8'(a);
    end else begin
      chain_b <= {chain_b[LB-2:0], sdo_b};
    end
  end

  always @(posedge sle_b) begin
    for (int a = 0; a < NDB; a++) latch_b[a] <= chain_b[8*a +: 8];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_mis = 0;
  int         last_rdy = 0;
  int         start_b = 0;
  logic [7:0] sb_q[$];
  logic [7:0] sb_big_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [8:0] s, input logic [7:0] d);
    active_select = s;
    inputs        = d;
    sb_q.push_back((s < 9'(ND)) ? (d ^ s[7:0]) : 8'h00);
  endtask

  // Waits (bounded) for ready, then checks the period and the scoreboard head.
  task automatic await_result(input string tag);
    bit         seen;
    logic [7:0] e;
    seen = 1'b0;
    for (int n = 0; n < T + 50; n++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1'b1;
        break;
      end
    end
    check_val({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check_val({tag, "_period"}, 32'(cyc - last_rdy), 32'(T));
      last_rdy = cyc;
    end
    check_val({tag, "_pending"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (seen) check_val({tag, "_out"}, 32'(outputs), 32'(e));
    end
  endtask

  initial begin
    fork
      begin : main_seq
        resetb = 1'b0;
        drive(9'd2, 8'hA5);
        repeat (3) @(negedge clk);
        check_val("rst_outs", 32'({outputs, ready, scan_clk, scan_data_out, scan_select, scan_latch_enable}), 32'd0);
        resetb   = 1'b1;
        last_rdy = cyc;
        await_result("a5");
        check_val("latch_s2", 32'(latch_m[2]), 32'hA5);
        check_val("latch_s0", 32'(latch_m[0]), 32'h00);
        check_val("latch_s1", 32'(latch_m[1]), 32'h00);
        check_val("latch_s3", 32'(latch_m[3]), 32'h00);

        drive(9'd0, 8'hFF);
        @(negedge clk);
        check_val("rdy_pulse", 32'(ready), 32'd0);
        check_val("out_hold", 32'(outputs), 32'hA7);
        repeat (8) @(negedge clk);
        drive(9'd3, 8'h3C);
        await_result("ff");
        await_result("3c");

        drive(9'd5, 8'h12);
        repeat (100) @(negedge clk);
        for (int n = 0; n < 4; n++) begin
          if (scan_clk) break;
          @(negedge clk);
        end
        check_val("pre_rst_sclk", 32'(scan_clk), 32'd1);
        resetb = 1'b0;
        #1;
        check_val("rst_mid", 32'({outputs, ready, scan_clk, scan_data_out, scan_select, scan_latch_enable}), 32'd0);
        sb_q.delete();
        drive(9'd1, 8'h55);
        @(negedge clk);
        resetb   = 1'b1;
        last_rdy = cyc;
        await_result("post_rst");

        drive(9'd5, 8'h12);
        await_result("oor0");
        check_val("oor_zero_load", 32'(latch_m[1]), 32'h00);
        drive(9'd5, 8'h12);
        await_result("oor1");
      end
      begin : big_seq
        bit seen_b;
        resetb_b = 1'b0;
        sel_b    = 9'd497;
        din_b    = 8'h81;
        sb_big_q.push_back(8'h81 ^ 8'(497));
        repeat (2) @(negedge clk);
        resetb_b = 1'b1;
        start_b  = cyc;
        seen_b   = 1'b0;
        for (int n = 0; n < TB + 100; n++) begin
          @(negedge clk);
          if (ready_b) begin
            seen_b = 1'b1;
            break;
          end
        end
        check_val("big_seen", 32'(seen_b), 32'd1);
        check_val("big_period", 32'(cyc - start_b), 32'(TB));
        check_val("big_pending", 32'(sb_big_q.size()), 32'd1);
        if (sb_big_q.size() > 0) check_val("big_out", 32'(outputs_b), 32'(sb_big_q.pop_front()));
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
